// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7920-class serial LCD path: FSM encodings,
// serial frame constants, request payload and default timing values that
// the LCD controller reuses.
package lcd_pkg;

    // Transmitter FSM encodings
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_TAIL_ENC  = 2'd2;
    localparam logic [1:0] ST_GAP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_TAIL  = ST_TAIL_ENC,
        ST_GAP   = ST_GAP_ENC
    } lcd_state_e;

    // Serial frame constants
    localparam logic [4:0] SYNC_PREFIX = 5'b11111;
    localparam logic       RW_WRITE    = 1'b0;
    localparam logic       RS_CMD      = 1'b0;
    localparam logic       RS_DATA     = 1'b1;

    localparam int unsigned FRAME_W = 24;
    localparam int unsigned BIT_W   = 5;

    // Default timing (100 MHz clk: 1 MHz SCLK, 80 us command gap)
    localparam int unsigned DEF_CLK_DIV    = 50;
    localparam int unsigned DEF_GAP_CYCLES = 8000;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // One command/data byte request
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_req_t;

    // Wrap a byte in the 24-bit serial frame, MSB transmitted first
    function automatic logic [FRAME_W-1:0] build_frame(input lcd_req_t req);
        return {SYNC_PREFIX, RW_WRITE, req.rs, 1'b0,
                req.data[7:4], 4'b0000, req.data[3:0], 4'b0000};
    endfunction

endpackage

// File: rtl/lcd_tx_fifo.sv
// Synchronous request queue placed in front of the serial transmitter.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push, wdata   - enqueue one request (caller never pushes when full)
//   pop           - dequeue the head entry (ignored when empty)
//   rdata_c       - head entry, valid while empty_q is low
//   empty_q       - registered empty flag
//   empty_nxt_c   - empty flag as it will be after this edge
//   full_nxt_c    - full flag as it will be after this edge
module lcd_tx_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  lcd_req_t wdata,
    input  logic     pop,
    output lcd_req_t rdata_c,
    output logic     empty_q,
    output logic     empty_nxt_c,
    output logic     full_nxt_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    lcd_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer/occupancy update; simultaneous push and pop keeps the count
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_nxt_c = (count_d == '0);
        full_nxt_c  = (count_d == CNT_W'(DEPTH));
        rdata_c     = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_nxt_c;
        end
    end

    // Storage needs no reset; entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/lcd_serial_tx.sv
// Byte-level transmitter for an ST7920-class LCD in 3-wire serial mode.
// Each byte is wrapped in a 24-bit frame, shifted MSB first, then followed
// by a command-execution gap before the next byte may start.
// Build option: define LCD_TX_FIFO_EN to place a FIFO_DEPTH-entry request
// queue in front of the FSM; serial timing is identical in both builds.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   I_valid/I_rs/I_data - byte request (rs: 0 = command, 1 = data)
//   O_ready           - request accepted when I_valid & O_ready
//   O_busy            - frame, gap or queued work in progress
//   O_done            - one-cycle pulse at the end of each byte's gap
//   O_cs1/O_sclk/O_sid - LCD serial interface
module lcd_serial_tx
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       I_valid,
    input  logic       I_rs,
    input  logic [7:0] I_data,
    output logic       O_ready,
    output logic       O_busy,
    output logic       O_done,
    output logic       O_cs1,
    output logic       O_sclk,
    output logic       O_sid
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    lcd_state_e         state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               cs1_q, cs1_d;
    logic               sclk_q, sclk_d;
    logic               sid_q, sid_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    lcd_req_t           req_in;
    lcd_req_t           start_req;
    logic               start_c;
    logic               div_end;

    assign req_in = '{rs: I_rs, data: I_data};

`ifdef LCD_TX_FIFO_EN
    logic fifo_empty_q;
    logic fifo_empty_nxt_c;
    logic fifo_full_nxt_c;
    logic fifo_push;

    // Accept into the queue; the FSM drains it whenever it is idle
    assign fifo_push = I_valid & ready_q;
    assign start_c   = (state_q == ST_IDLE) & ~fifo_empty_q;

    lcd_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .wdata       (req_in),
        .pop         (start_c),
        .rdata_c     (start_req),
        .empty_q     (fifo_empty_q),
        .empty_nxt_c (fifo_empty_nxt_c),
        .full_nxt_c  (fifo_full_nxt_c)
    );
`else
    // Direct handshake: a byte is taken only while the FSM is idle
    assign start_c   = I_valid & ready_q;
    assign start_req = req_in;
`endif

    assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

    // Next-state and serial output logic
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        cs1_d   = cs1_q;
        sclk_d  = sclk_q;
        sid_d   = sid_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_SHIFT;
                    frame_d = build_frame(start_req);
                    cs1_d   = 1'b1;
                    sclk_d  = 1'b0;
                    sid_d   = frame_d[FRAME_W-1];
                    div_d   = '0;
                    bit_d   = BIT_W'(FRAME_W - 1);
                end
            end

            ST_SHIFT: begin
                if (div_end) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: the only place SID moves
                        sclk_d = 1'b0;
                        if (bit_q == '0) begin
                            state_d = ST_TAIL;
                        end else begin
                            bit_d   = bit_q - BIT_W'(1);
                            frame_d = {frame_q[FRAME_W-2:0], 1'b0};
                            sid_d   = frame_q[FRAME_W-2];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_TAIL: begin
                if (div_end) begin
                    div_d = '0;
                    cs1_d = 1'b0;
                    sid_d = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake status, registered alongside the FSM
    always_comb begin
`ifdef LCD_TX_FIFO_EN
        ready_d = ~fifo_full_nxt_c;
        busy_d  = (state_d != ST_IDLE) | ~fifo_empty_nxt_c;
`else
        ready_d = (state_d == ST_IDLE);
        busy_d  = ~ready_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            frame_q <= '0;
            cs1_q   <= 1'b0;
            sclk_q  <= 1'b0;
            sid_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            cs1_q   <= cs1_d;
            sclk_q  <= sclk_d;
            sid_q   <= sid_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign O_ready = ready_q;
    assign O_busy  = busy_q;
    assign O_done  = done_q;
    assign O_cs1   = cs1_q;
    assign O_sclk  = sclk_q;
    assign O_sid   = sid_q;

endmodule
